// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS interrupt controller slice.
// Holds the FSM state encoding and the default ISR vector layout.
package mips_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [15:0] VEC_BASE_DEF   = 16'h0040;
    localparam logic [15:0] VEC_STRIDE_DEF = 16'h0004;

endpackage

// File: rtl/mips_irq_controller_if.sv
// Bus between request sources / core and the interrupt controller.
// Ports: requests, mask write, irq_done in; pulse, vector, status out.
interface mips_irq_controller_if #(
    parameter int NUM_IRQ = 4
);

    logic [NUM_IRQ-1:0] irq_in;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_in;
    logic               irq_done;
    logic               interrupt;
    logic [15:0]        isr_addr;
    logic [2:0]         active_id;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;

    modport master (
        output irq_in, mask_we, mask_in, irq_done,
        input  interrupt, isr_addr, active_id,
        input  in_service, pending, mask
    );

    modport slave (
        input  irq_in, mask_we, mask_in, irq_done,
        output interrupt, isr_addr, active_id,
        output in_service, pending, mask
    );

endinterface

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: lowest set index of eligible wins.
// Ports: eligible in; valid and 3-bit index out (index 0 when none).
module irq_priority_enc #(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] eligible,
    output logic               valid,
    output logic [2:0]         index
);

    // Scan downward so the last hit, the lowest index, is kept.
    always_comb begin
        valid = 1'b0;
        index = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                valid = 1'b1;
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/mips_irq_controller.sv
// Edge-detecting, fixed-priority, non-nesting interrupt controller.
// Ports: clk, reset (sync, active-high), bus (slave side of the irq bus).
module mips_irq_controller
    import mips_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input logic                 clk,
    input logic                 reset,
    mips_irq_controller_if.slave bus
);

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] events;
    logic [NUM_IRQ-1:0] clr;
    logic               enc_valid;
    logic [2:0]         enc_idx;
    logic               sel;
    logic               interrupt;
    logic               in_service;
    logic [15:0]        isr_addr;
    logic [2:0]         active_id;

    assign events = bus.irq_in & ~irq_prev;

    irq_priority_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_enc (
        .eligible (pending & mask),
        .valid    (enc_valid),
        .index    (enc_idx)
    );

    assign sel = (state == ST_IDLE) && enc_valid;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = sel && (enc_idx == 3'(i));
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (enc_valid) state_next = ST_ISSUE;
            ST_ISSUE:   state_next = ST_SERVICE;
            ST_SERVICE: if (bus.irq_done) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            irq_prev   <= '0;
            pending    <= '0;
            mask       <= '0;
            interrupt  <= 1'b0;
            in_service <= 1'b0;
            isr_addr   <= 16'h0000;
            active_id  <= 3'd0;
        end else begin
            state      <= state_next;
            irq_prev   <= bus.irq_in;
            // A new event on the bit being cleared keeps it set.
            pending    <= (pending & ~clr) | events;
            if (bus.mask_we) mask <= bus.mask_in;
            interrupt  <= (state_next == ST_ISSUE);
            in_service <= (state_next != ST_IDLE);
            if (sel) begin
                active_id <= enc_idx;
                isr_addr  <= VEC_BASE + {13'd0, enc_idx} * VEC_STRIDE;
            end
        end
    end

    assign bus.interrupt  = interrupt;
    assign bus.in_service = in_service;
    assign bus.isr_addr   = isr_addr;
    assign bus.active_id  = active_id;
    assign bus.pending    = pending;
    assign bus.mask       = mask;

endmodule
